mac_result_collector: RTL and testbench

- Downstream consumer of the 16-tap pipelined MAC wrapper.
- Issues single-cycle start pulses to the MAC and captures each 32-bit result on its valid strobe.
- Scales each result (arithmetic right shift, then saturation to OUT_W) and buffers it in a FIFO.
- Drains the FIFO over a valid/ready stream to the next stage, with flow control so no result is ever dropped.

---
 rtl/mac_pkg.sv | 63 ++++++
 rtl/sync_fifo_fwft.sv | 86 ++++++++
 rtl/mac_result_collector.sv | 133 +++++++++++++
 tb/tb_mac_result_collector.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// ----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC back-end blocks.
//   state_t        : request/capture FSM states (IDLE, ISSUE, WAIT)
//   OUT_W_DEF      : default output sample width
//   calc_t         : wide signed type used for scaling arithmetic
//   sat_max/sat_min: saturation limits derived from an output width
//   scale_saturate : arithmetic right shift followed by clamping to out_w bits
// ----------------------------------------------------------------------------
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int OUT_W_DEF = 16;
    localparam int CALC_W    = 64;

    typedef logic signed [CALC_W-1:0] calc_t;

    typedef struct packed {
        calc_t value;
        logic  clamped;
    } scale_res_t;

    // Largest value representable in an out_w-bit signed sample.
    function automatic calc_t sat_max(input int out_w);
        return (calc_t'(1) <<< (out_w - 1)) - calc_t'(1);
    endfunction

    // Most negative value representable in an out_w-bit signed sample.
    function automatic calc_t sat_min(input int out_w);
        return -(calc_t'(1) <<< (out_w - 1));
    endfunction

    // Shift right with sign extension, then clamp into the signed range of
    // out_w bits. The caller passes an already sign-extended input so the
    // same function serves back-ends with different result widths.
    function automatic scale_res_t scale_saturate(input calc_t din,
                                                  input int    shift,
                                                  input int    out_w);
        calc_t      s;
        calc_t      hi;
        calc_t      lo;
        scale_res_t r;
        s         = din >>> shift;
        hi        = sat_max(out_w);
        lo        = sat_min(out_w);
        r.value   = s;
        r.clamped = 1'b0;
        if (s > hi) begin
            r.value   = hi;
            r.clamped = 1'b1;
        end else if (s < lo) begin
            r.value   = lo;
            r.clamped = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// ----------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO. The head entry is presented on
// rd_data whenever rd_valid is high; rd_en pops it on the next clock edge.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset, clears pointers and level
//   wr_en    : write request
//   wr_data  : data to write
//   wr_ok    : write request will be accepted on this edge
//   rd_en    : pop request (ignored while empty)
//   rd_data  : head entry (zero while empty)
//   rd_valid : FIFO non-empty
//   level    : current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module sync_fifo_fwft #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   wr_ok,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] level
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;

    logic w_empty;
    logic w_full;
    logic w_rd;
    logic w_wr;

    // Full/empty come from the occupancy counter rather than pointer
    // comparison. A pop on the same edge frees a slot, so a write while full
    // is still accepted when the head is being consumed.
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == FULL_LVL);
    assign w_rd    = rd_en && !w_empty;
    assign w_wr    = wr_en && (!w_full || w_rd);

    assign wr_ok    = w_wr;
    assign rd_valid = !w_empty;
    assign level    = r_level;
    assign rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array; contents are only meaningful between the pointers, so
    // it carries no reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + (AW + 1)'(1);
                2'b01:   r_level <= r_level - (AW + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/mac_result_collector.sv
// ----------------------------------------------------------------------------
// mac_result_collector
// Requests operations from the pipelined MAC, captures each result on its
// valid strobe, scales it (arithmetic shift + saturation) and queues it in a
// FWFT FIFO that is drained over a valid/ready stream.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   run_en     : keep requesting MAC operations while high
//   mac_start  : one-cycle start pulse to the MAC
//   mac_busy   : MAC busy flag
//   mac_valid  : MAC result strobe
//   mac_result : MAC result, sampled when mac_valid is high
//   out_data   : scaled sample at the FIFO head
//   out_valid  : FIFO non-empty
//   out_ready  : downstream accepts when out_valid && out_ready
//   level      : FIFO occupancy
//   sat_cnt    : number of clamped samples stored, sticks at 0xFFFF
// ----------------------------------------------------------------------------
module mac_result_collector
    import mac_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int SHIFT  = 8,
    parameter int DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run_en,
    output logic                   mac_start,
    input  logic                   mac_busy,
    input  logic                   mac_valid,
    input  logic [DATA_W-1:0]      mac_result,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            sat_cnt
);

    state_t r_state;
    state_t w_next_state;

    logic                   w_mac_start;
    logic                   w_pending;
    logic                   w_room;
    logic [$clog2(DEPTH):0] w_level;
    logic                   w_wr_ok;
    scale_res_t             w_scale;
    calc_t                  w_scaled_val;
    logic [OUT_W-1:0]       w_sample;
    logic [15:0]            r_sat_cnt;

    // A start is only issued when a FIFO slot is guaranteed for its result:
    // the operation in flight (pending) counts as already occupying a slot.
    assign w_pending = (r_state != IDLE);
    assign w_room    = (int'(w_level) + int'(w_pending)) < DEPTH;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and start pulse. Dropping run_en never aborts an issued
    // operation; WAIT always runs to the result strobe.
    always_comb begin
        w_next_state = r_state;
        w_mac_start  = 1'b0;
        case (r_state)
            IDLE: begin
                if (run_en && !mac_busy && w_room) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                w_mac_start  = 1'b1;
                w_next_state = WAIT;
            end
            WAIT: begin
                if (mac_valid) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign mac_start = w_mac_start;

    // Scale the raw result before it enters the FIFO.
    assign w_scale      = scale_saturate(calc_t'(signed'(mac_result)), SHIFT, OUT_W);
    assign w_scaled_val = w_scale.value;
    assign w_sample     = OUT_W'(w_scaled_val);

    // Every mac_valid is offered to the FIFO, including strobes arriving
    // outside WAIT; the FIFO refuses it only when full with no pop.
    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (mac_valid),
        .wr_data  (w_sample),
        .wr_ok    (w_wr_ok),
        .rd_en    (out_ready),
        .rd_data  (out_data),
        .rd_valid (out_valid),
        .level    (w_level)
    );

    assign level = w_level;

    // Saturation counter: counts clamped samples that were actually stored
    // and sticks at its maximum instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sat_cnt <= '0;
        end else if (w_wr_ok && w_scale.clamped && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign sat_cnt = r_sat_cnt;

endmodule

// File: tb/tb_mac_result_collector.sv
// ----------------------------------------------------------------------------
// tb_mac_result_collector
// Cycle-based bench: a behavioural MAC drives start/busy/valid, and a queue
// model of the FIFO contents predicts every output after each clock edge.
// ----------------------------------------------------------------------------
module tb_mac_result_collector;

    localparam int DATA_W = 32;
    localparam int OUT_W  = 16;
    localparam int SHIFT  = 8;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              run_en;
    logic              mac_start;
    logic              mac_busy;
    logic              mac_valid;
    logic [DATA_W-1:0] mac_result;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        level;
    logic [15:0]       sat_cnt;

    int errors = 0;
    int checks = 0;

    logic [15:0] modelQ[$];
    logic [31:0] resQ[$];
    int modelSat    = 0;
    int outstanding = 0;
    int startCount  = 0;
    bit prevStart   = 1'b0;
    bit macActive   = 1'b0;
    int macCnt      = 0;
    int latMin      = 1;
    int latMax      = 1;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    mac_result_collector #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W),
        .SHIFT  (SHIFT),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run_en     (run_en),
        .mac_start  (mac_start),
        .mac_busy   (mac_busy),
        .mac_valid  (mac_valid),
        .mac_result (mac_result),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .sat_cnt    (sat_cnt)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference scaling: floor division by 2^SHIFT, then clamp to the
    // signed OUT_W range.
    function automatic logic [15:0] refScale(input logic [31:0] r, output bit clamp);
        longint v;
        longint s;
        longint div;
        longint hi;
        longint lo;
        div = 1;
        repeat (SHIFT) div = div * 2;
        hi = 1;
        repeat (OUT_W - 1) hi = hi * 2;
        lo = -hi;
        hi = hi - 1;
        v = longint'(signed'(r));
        if (v >= 0) s = v / div;
        else        s = -((-v + div - 1) / div);
        clamp = 1'b0;
        if (s > hi) begin
            s = hi;
            clamp = 1'b1;
        end else if (s < lo) begin
            s = lo;
            clamp = 1'b1;
        end
        return s[15:0];
    endfunction

    // Random MAC results covering full range, small values of both signs
    // and values right at the clamping thresholds.
    function automatic logic [31:0] randResult();
        logic [31:0] r;
        int sel;
        sel = $urandom_range(3, 0);
        case (sel)
            0: r = $urandom;
            1: r = $urandom_range(32'h00FF_FFFF, 0);
            2: r = 32'd0 - $urandom_range(32'h00FF_FFFF, 0);
            default: begin
                r = 32'h0080_0000 - 32'd256 + 32'($urandom_range(511, 0));
                if ($urandom_range(1, 0) == 1) r = ~r;
            end
        endcase
        return r;
    endfunction

    // One clock: account for the edge in the model, compare all outputs,
    // then let the MAC model choose its inputs for the next edge.
    task automatic applyStimulus();
        int          preSize;
        bit          rd;
        bit          acc;
        bit          clamp;
        bit          ok;
        logic [15:0] v;
        @(posedge clk);
        #1;
        preSize = modelQ.size();
        rd = out_ready && (preSize > 0);
        if (rd) void'(modelQ.pop_front());
        if (mac_valid) begin
            acc = (preSize < DEPTH) || rd;
            checkOutput("noDrop", 64'(acc), 64'd1);
            if (acc) begin
                v = refScale(mac_result, clamp);
                modelQ.push_back(v);
                if (clamp && modelSat < 65535) modelSat++;
            end
            if (outstanding > 0) outstanding--;
        end
        checkOutput("level", 64'(level), 64'(modelQ.size()));
        checkOutput("outValid", 64'(out_valid), 64'(modelQ.size() > 0));
        if (modelQ.size() > 0) checkOutput("outData", 64'(out_data), 64'(modelQ[0]));
        checkOutput("satCnt", 64'(sat_cnt), 64'(modelSat));
        if (mac_start) begin
            ok = !prevStart && !mac_busy && run_en && (outstanding == 0) && (preSize < DEPTH);
            checkOutput("startLegal", 64'(ok), 64'd1);
            startCount++;
            outstanding++;
        end
        prevStart = mac_start;
        mac_valid  = 1'b0;
        mac_result = $urandom;
        if (macActive) begin
            macCnt--;
            if (macCnt <= 0) begin
                mac_valid = 1'b1;
                if (resQ.size() > 0) mac_result = resQ.pop_front();
                else                 mac_result = randResult();
                macActive = 1'b0;
                mac_busy  = 1'b0;
            end
        end
        if (mac_start) begin
            macActive = 1'b1;
            macCnt    = $urandom_range(latMax, latMin);
            mac_busy  = 1'b1;
        end
    endtask

    // Issue exactly n operations and wait for all of their results.
    task automatic runOps(input int n);
        int base;
        int guard;
        base  = startCount;
        guard = 0;
        run_en = 1'b1;
        while (startCount < base + n && guard < 400) begin
            applyStimulus();
            guard++;
        end
        run_en = 1'b0;
        checkOutput("opsIssued", 64'(startCount - base), 64'(n));
        guard = 0;
        while ((macActive || outstanding > 0) && guard < 100) begin
            applyStimulus();
            guard++;
        end
        checkOutput("opsDone", 64'(outstanding), 64'd0);
    endtask

    // Empty the FIFO through the stream port.
    task automatic drain();
        int guard;
        guard = 0;
        out_ready = 1'b1;
        while (modelQ.size() > 0 && guard < 40) begin
            applyStimulus();
            guard++;
        end
        out_ready = 1'b0;
        checkOutput("drained", 64'(level), 64'd0);
    endtask

    // Assert reset between clock edges and check that outputs clear at once.
    task automatic resetMidCycle();
        #3 reset = 1'b0;
        #1;
        checkOutput("rstStart", 64'(mac_start), 64'd0);
        checkOutput("rstValid", 64'(out_valid), 64'd0);
        checkOutput("rstData", 64'(out_data), 64'd0);
        checkOutput("rstLevel", 64'(level), 64'd0);
        checkOutput("rstSat", 64'(sat_cnt), 64'd0);
        modelQ.delete();
        modelSat    = 0;
        outstanding = 0;
        prevStart   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
    endtask

    // Safety net so the run always terminates.
    initial begin
        #2_000_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Main sequence.
    initial begin
        int base;
        int guard;
        reset      = 1'b0;
        run_en     = 1'b0;
        mac_busy   = 1'b0;
        mac_valid  = 1'b0;
        mac_result = '0;
        out_ready  = 1'b0;
        #2;
        checkOutput("initStart", 64'(mac_start), 64'd0);
        checkOutput("initValid", 64'(out_valid), 64'd0);
        checkOutput("initData", 64'(out_data), 64'd0);
        checkOutput("initLevel", 64'(level), 64'd0);
        checkOutput("initSat", 64'(sat_cnt), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;

        $display("[TB] single operation");
        latMin = 20;
        latMax = 20;
        resQ.push_back(32'h0001_2300);
        base = startCount;
        runOps(1);
        repeat (10) applyStimulus();
        checkOutput("singleStarts", 64'(startCount - base), 64'd1);
        checkOutput("singleData", 64'(out_data), 64'h0123);
        checkOutput("singleValid", 64'(out_valid), 64'd1);
        checkOutput("singleSat", 64'(sat_cnt), 64'd0);
        drain();

        $display("[TB] saturation");
        latMin = 3;
        latMax = 3;
        resQ.push_back(32'h7FFF_FFFF);
        resQ.push_back(32'h8000_0000);
        runOps(2);
        checkOutput("satLevel", 64'(level), 64'd2);
        checkOutput("satHigh", 64'(out_data), 64'h7FFF);
        checkOutput("satCount", 64'(sat_cnt), 64'd2);
        out_ready = 1'b1;
        applyStimulus();
        out_ready = 1'b0;
        checkOutput("satLow", 64'(out_data), 64'h8000);
        drain();

        $display("[TB] negative without clamp");
        resQ.push_back(32'hFFFF_FF00);
        runOps(1);
        checkOutput("negData", 64'(out_data), 64'hFFFF);
        checkOutput("negSat", 64'(sat_cnt), 64'd2);
        drain();

        $display("[TB] backpressure");
        latMin = 2;
        latMax = 2;
        base = startCount;
        run_en = 1'b1;
        repeat (150) applyStimulus();
        checkOutput("bpStarts", 64'(startCount - base), 64'd8);
        checkOutput("bpLevel", 64'(level), 64'd8);
        checkOutput("bpNoStart", 64'(mac_start), 64'd0);
        out_ready = 1'b1;
        applyStimulus();
        out_ready = 1'b0;
        checkOutput("bpPopLevel", 64'(level), 64'd7);
        repeat (40) applyStimulus();
        checkOutput("bpOneMore", 64'(startCount - base), 64'd9);
        checkOutput("bpRefill", 64'(level), 64'd8);
        run_en = 1'b0;
        repeat (5) applyStimulus();

        $display("[TB] write and read together while full");
        mac_valid  = 1'b1;
        mac_result = 32'h0005_5500;
        out_ready  = 1'b1;
        applyStimulus();
        checkOutput("fullRwLevel", 64'(level), 64'd8);
        drain();

        $display("[TB] reset while waiting for a result");
        latMin = 20;
        latMax = 20;
        base = startCount;
        guard = 0;
        run_en = 1'b1;
        while (startCount == base && guard < 50) begin
            applyStimulus();
            guard++;
        end
        repeat (3) applyStimulus();
        resetMidCycle();
        base = startCount;
        guard = 0;
        while (startCount == base && guard < 60) begin
            applyStimulus();
            guard++;
        end
        checkOutput("postResetStart", 64'(startCount - base), 64'd1);
        run_en = 1'b0;
        guard = 0;
        while ((macActive || outstanding > 0) && guard < 60) begin
            applyStimulus();
            guard++;
        end
        checkOutput("postResetLevel", 64'(level), 64'd2);
        drain();

        $display("[TB] randomized traffic");
        latMin = 1;
        latMax = 6;
        for (int i = 0; i < 1500; i++) begin
            if (((i / 100) % 2) == 1) out_ready = ($urandom_range(7, 0) == 0);
            else                      out_ready = ($urandom_range(3, 0) != 0);
            run_en = ($urandom_range(7, 0) != 0);
            applyStimulus();
        end
        run_en = 1'b0;
        guard = 0;
        while ((macActive || outstanding > 0) && guard < 60) begin
            applyStimulus();
            guard++;
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
